// File: rtl/ternary_neuron_acc19.sv
// Ternary-neuron back end: accumulates saturated (pos - neg) popcount differences over
// one or more chunks, thresholds the total into a trit, and holds it behind valid/ready.
module ternary_neuron_acc19 #(
  parameter int unsigned ACC_W = 10,
  parameter int          TH_HI = 4,
  parameter int          TH_LO = -4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       pc_pos,
  input  logic [4:0]       pc_neg,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       out_trit,
  output logic [ACC_W-1:0] out_sum,
  output logic [7:0]       out_beats
);

  localparam int unsigned SUM_W = ACC_W + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]              state;
  logic [1:0]              state_next;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [SUM_W-1:0] sum_wide;
  logic [7:0]              beats;
  logic [7:0]              beats_d;
  logic [7:0]              beats_inc;
  logic [1:0]              trit_next;
  logic                    load_result;
  logic                    accept;

  // One extra bit catches overflow; disagreeing top bits mean the value left the ACC_W range.
  always_comb begin
    sum_wide = $signed({acc[ACC_W-1], acc})
             + $signed(SUM_W'(pc_pos))
             - $signed(SUM_W'(pc_neg));
    if (sum_wide[SUM_W-1] != sum_wide[ACC_W-1]) begin
      acc_sat = sum_wide[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                  : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      acc_sat = sum_wide[ACC_W-1:0];
    end
    beats_inc = (beats == 8'hFF) ? beats : beats + 8'd1;
    if (int'(acc_sat) >= TH_HI) begin
      trit_next = 2'b01;
    end else if (int'(acc_sat) <= TH_LO) begin
      trit_next = 2'b11;
    end else begin
      trit_next = 2'b00;
    end
  end

  assign accept = in_valid & in_ready;

  // Next-state and accumulator update.
  always_comb begin
    state_next  = state;
    acc_d       = acc;
    beats_d     = beats;
    load_result = 1'b0;
    case (state)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_d   = acc_sat;
          beats_d = beats_inc;
          if (in_last) begin
            state_next  = HOLD;
            load_result = 1'b1;
          end else begin
            state_next = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next = IDLE;
          acc_d      = '0;
          beats_d    = '0;
        end
      end
      default: begin
        state_next = IDLE;
        acc_d      = '0;
        beats_d    = '0;
      end
    endcase
  end

  // in_ready/out_valid are decoded from the next state so they are pure flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      beats     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_trit  <= 2'b00;
      out_sum   <= '0;
      out_beats <= '0;
    end else begin
      state     <= state_next;
      acc       <= acc_d;
      beats     <= beats_d;
      in_ready  <= (state_next != HOLD);
      out_valid <= (state_next == HOLD);
      if (load_result) begin
        out_trit  <= trit_next;
        out_sum   <= acc_sat;
        out_beats <= beats_inc;
      end
    end
  end

endmodule

// File: doc/ternary_neuron_acc19.md
# ternary_neuron_acc19

Sequential ternary-neuron back end that consumes the 5-bit results of two 19-input popcount stages: one over inputs with +1 weights, one over inputs with -1 weights. Over one or more 19-input chunks of a neuron's fan-in, it accumulates the signed difference of the two counts. It then thresholds the total into a ternary activation and holds the result behind a valid/ready handshake. It sits directly downstream of the popcount19 circuits in the printed-NN datapath.

## Interface
- ACC_W, 10, signed accumulator / out_sum width (min 6)
- TH_HI, 4, signed upper threshold; sum >= TH_HI gives +1
- TH_LO, -4, signed lower threshold; sum <= TH_LO gives -1; TH_LO < TH_HI required
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc_pos  in  5  unsigned popcount of +1-weighted inputs for current chunk (0..31 accepted as-is)
- pc_neg  in  5  unsigned popcount of -1-weighted inputs for current chunk
- in_valid  in  1  chunk beat valid
- in_last  in  1  beat is final chunk of the neuron; qualified by in_valid
- in_ready  out  1  block accepts a beat
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_trit  out  2  2'b01 = +1, 2'b11 = -1, 2'b00 = 0
- out_sum  out  ACC_W  signed saturated final sum
- out_beats  out  8  number of beats accumulated, saturating at 255

## Operation
- States: IDLE, ACCUM, HOLD.
  - IDLE: acc = 0, beats = 0, in_ready = 1.
  - ACCUM: in_ready = 1.
  - HOLD: in_ready = 0, out_valid = 1.
- Beat accepted when in_valid & in_ready.
  - acc_next = sat(acc + pc_pos - pc_neg).
  - beats_next = min(beats + 1, 255).
- sat clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Compute in ACC_W+1 bits, then clamp.
  - Saturation is sticky only through subsequent arithmetic; later beats may pull the value back in range.
- Transitions:
  - IDLE, accepted beat with in_last = 0 -> ACCUM.
  - IDLE or ACCUM, accepted beat with in_last = 1 -> HOLD. out_sum, out_trit and out_beats are registered from acc_next/beats_next.
  - HOLD, out_ready = 1 -> IDLE. acc and beats are cleared.
- Trit: +1 if sum >= TH_HI; -1 if sum <= TH_LO; else 0. Comparisons are signed.
- In HOLD, out_sum/out_trit/out_beats are stable; pc_*, in_valid and in_last are ignored.
- in_valid low in ACCUM: state and acc hold indefinitely.
- Reset values:
  - state IDLE, acc 0, beats 0.
  - in_ready 1, out_valid 0, out_trit 2'b00, out_sum 0, out_beats 0.
- rst in any state, including mid-accumulation or HOLD, discards the partial/held result the next edge. A beat presented in the reset cycle is not accepted.

## Timing
- in_ready is a registered state decode; no combinational path from out_ready to in_ready.
- Last beat accepted at edge N -> out_valid = 1 from edge N through the handshake edge.
- Output handshake at edge M -> out_valid = 0 and in_ready = 1 after edge M. The earliest next beat is accepted at edge M+1 (one bubble cycle per neuron).
- Single-beat neuron: one beat in IDLE with in_last = 1 -> result valid the next cycle.
- Throughput: K-beat neuron occupies K + 1 + (out_ready stall) cycles.
- Result outputs change only on the edge entering HOLD or on reset. Outside HOLD they keep their last values and are don't-care to consumers.

## Test plan
- Single beat, defaults: pc_pos = 12, pc_neg = 3, in_last = 1 -> next cycle out_valid = 1, out_sum = 9, out_trit = 01, out_beats = 1, in_ready = 0.
- Three beats (5,10), (2,9), (0,4), last on the third, with in_valid gaps of 2 cycles between beats -> out_sum = -16, out_trit = 11, out_beats = 3.
- Threshold boundaries, single beat each, defaults:
  - sums 4 and 3 -> trits 01 and 00.
  - sums -4 and -3 -> trits 11 and 00.
- Backpressure: result ready, out_ready = 0 for 5 cycles while driving in_valid = 1 with random pc_* -> outputs unchanged and no beat consumed. Then out_ready = 1 -> out_valid = 0 next cycle, in_ready = 1, and the next beat starts from acc = 0.
- Saturation, ACC_W = 6: beats (19,0), (19,0), (0,5) with last -> clamp to 31 after beat 2, out_sum = 26, out_trit = 01.
  - Negative case (0,19) x 2 with last on the second -> out_sum = -32.
- Reset: rst asserted after 2 of 4 beats -> in_ready = 1, out_valid = 0. A new single beat (1,0, last) gives out_sum = 1, out_beats = 1.
  - rst asserted in HOLD -> out_valid = 0 next cycle.
